game_flow_ctrl: RTL and testbench

Top-level game sequencer for the breakout datapath. It debounces the start button and drives `game_state` and `game_reset` into the ball/racket mover. It consumes `lose_sig` and the per-brick collision vector to track lives, score and bricks remaining, and decides game-over and win. It sits between the button inputs, the brick-wall block and the ball/racket mover.

---
 rtl/game_flow_ctrl.sv | 186 ++++++++++++++++++
 tb/tb_game_flow_ctrl.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/game_flow_ctrl.sv
// Breakout game sequencer: debounces the start button, runs the
// idle/serve/play/over/win flow, and tracks lives, score and bricks left.
module game_flow_ctrl #(
    parameter int NUM_BRICKS      = 50,
    parameter int INIT_LIVES      = 3,
    parameter int DEBOUNCE_CYC    = 250000,
    parameter int RESET_CYC       = 4,
    parameter int SCORE_PER_BRICK = 10
) (
    input  logic                  vga_clk,
    input  logic                  sys_rst_n,
    input  logic                  start,
    input  logic                  lose_sig,
    input  logic [NUM_BRICKS-1:0] brick_collision,
    output logic [1:0]            game_state,
    output logic                  game_reset,
    output logic [1:0]            lives,
    output logic [15:0]           score,
    output logic [5:0]            bricks_left
);

    localparam int DB_W = (DEBOUNCE_CYC > 1) ? $clog2(DEBOUNCE_CYC) : 1;
    localparam int SV_W = (RESET_CYC > 1) ? $clog2(RESET_CYC) : 1;

    localparam logic [DB_W-1:0] DB_LAST     = DB_W'(DEBOUNCE_CYC - 1);
    localparam logic [SV_W-1:0] SV_LAST     = SV_W'(RESET_CYC - 1);
    localparam logic [1:0]      LIVES_INIT  = 2'(INIT_LIVES);
    localparam logic [5:0]      BRICKS_INIT = 6'(NUM_BRICKS);
    localparam logic [16:0]     SCORE_STEP  = 17'(SCORE_PER_BRICK);

    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_SERVE = 3'd1;
    localparam logic [2:0] ST_PLAY  = 3'd2;
    localparam logic [2:0] ST_OVER  = 3'd3;
    localparam logic [2:0] ST_WIN   = 3'd4;

    logic [1:0]            sync_q;
    logic                  pressed;
    logic                  stable_pressed;
    logic                  pulse_prev;
    logic [DB_W-1:0]       db_cnt;
    logic                  start_pulse;

    logic [NUM_BRICKS-1:0] prev_collision;
    logic [NUM_BRICKS-1:0] new_hits;
    logic [5:0]            hit_cnt;
    logic [5:0]            bricks_upd;
    logic [16:0]           score_sum;
    logic [15:0]           score_upd;

    logic [2:0]            state, state_nxt;
    logic [SV_W-1:0]       serve_cnt, serve_nxt;
    logic [1:0]            lives_nxt;
    logic [15:0]           score_nxt;
    logic [5:0]            bricks_nxt;
    logic [1:0]            game_state_nxt;
    logic                  game_reset_nxt;

    // Two-flop synchroniser for the raw, active-low button (idles released = 1).
    always_ff @(posedge vga_clk) begin
        // NOTE: non-blocking assignments in clocked blocks so every flop samples pre-edge values.
        if (!sys_rst_n) sync_q <= 2'b11;
        else            sync_q <= {sync_q[0], start};
    end

    assign pressed = ~sync_q[1];

    // Debounce: accept a level change only after it has held DEBOUNCE_CYC cycles.
    always_ff @(posedge vga_clk) begin
        if (!sys_rst_n) begin
            stable_pressed <= 1'b0;
            db_cnt         <= '0;
            pulse_prev     <= 1'b0;
        end else begin
            pulse_prev <= stable_pressed;
            if (pressed == stable_pressed) begin
                db_cnt <= '0;
            end else if (db_cnt == DB_LAST) begin
                stable_pressed <= pressed;
                db_cnt         <= '0;
            end else begin
                db_cnt <= db_cnt + 1'b1;
            end
        end
    end

    // One pulse per accepted press; holding the button does not repeat it.
    assign start_pulse = stable_pressed & ~pulse_prev;

    // Keep last cycle's collision flags so only rising edges count as hits.
    always_ff @(posedge vga_clk) begin
        if (!sys_rst_n) prev_collision <= '0;
        else            prev_collision <= brick_collision;
    end

    assign new_hits = brick_collision & ~prev_collision;

    // Count new hits and form the floored brick count and saturated score.
    always_comb begin
        // NOTE: every combinational output gets a default first so no latch is inferred.
        hit_cnt = '0;
        for (int i = 0; i < NUM_BRICKS; i++) begin
            hit_cnt = hit_cnt + 6'(new_hits[i]);
        end
        bricks_upd = (bricks_left > hit_cnt) ? (bricks_left - hit_cnt) : 6'd0;
        score_sum  = {1'b0, score} + (17'(hit_cnt) * SCORE_STEP);
        score_upd  = score_sum[16] ? 16'hFFFF : score_sum[15:0];
    end

    // Next-state logic: game flow, life accounting and new-game loads.
    always_comb begin
        state_nxt  = state;
        serve_nxt  = serve_cnt;
        lives_nxt  = lives;
        score_nxt  = score;
        bricks_nxt = bricks_left;
        case (state)
            ST_IDLE, ST_OVER, ST_WIN: begin
                if (start_pulse) begin
                    state_nxt  = ST_SERVE;
                    serve_nxt  = '0;
                    lives_nxt  = LIVES_INIT;
                    score_nxt  = '0;
                    bricks_nxt = BRICKS_INIT;
                end
            end
            ST_SERVE: begin
                if (serve_cnt == SV_LAST) state_nxt = ST_PLAY;
                else                      serve_nxt = serve_cnt + 1'b1;
            end
            ST_PLAY: begin
                score_nxt  = score_upd;
                bricks_nxt = bricks_upd;
                // The last brick wins even if the ball is lost in the same cycle.
                if (bricks_upd == 6'd0) begin
                    state_nxt = ST_WIN;
                end else if (lose_sig) begin
                    if (lives > 2'd1) begin
                        lives_nxt = lives - 1'b1;
                        state_nxt = ST_SERVE;
                        serve_nxt = '0;
                    end else begin
                        lives_nxt = 2'd0;
                        state_nxt = ST_OVER;
                    end
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    // Decode the registered outputs from the next state so they track the state flop.
    always_comb begin
        game_state_nxt = 2'b00;
        game_reset_nxt = 1'b0;
        case (state_nxt)
            ST_SERVE: game_reset_nxt = 1'b1;
            ST_PLAY:  game_state_nxt = 2'b01;
            ST_OVER:  game_state_nxt = 2'b10;
            ST_WIN:   game_state_nxt = 2'b11;
            default:  game_state_nxt = 2'b00;
        endcase
    end

    // State, counters and all outputs register together.
    always_ff @(posedge vga_clk) begin
        if (!sys_rst_n) begin
            state       <= ST_IDLE;
            serve_cnt   <= '0;
            lives       <= LIVES_INIT;
            score       <= '0;
            bricks_left <= BRICKS_INIT;
            game_state  <= 2'b00;
            game_reset  <= 1'b0;
        end else begin
            state       <= state_nxt;
            serve_cnt   <= serve_nxt;
            lives       <= lives_nxt;
            score       <= score_nxt;
            bricks_left <= bricks_nxt;
            game_state  <= game_state_nxt;
            game_reset  <= game_reset_nxt;
        end
    end

endmodule

// File: tb/tb_game_flow_ctrl.sv
// Directed self-checking bench for game_flow_ctrl (short debounce for simulation speed).
module tb_game_flow_ctrl;

    localparam int NB  = 50;
    localparam int DEB = 20;
    localparam int RC  = 4;

    logic          vga_clk = 1'b0;
    logic          sys_rst_n = 1'b0;
    logic          start = 1'b1;
    logic          lose_sig = 1'b0;
    logic [NB-1:0] brick_collision = '0;
    logic [1:0]    game_state;
    logic          game_reset;
    logic [1:0]    lives;
    logic [15:0]   score;
    logic [5:0]    bricks_left;

    int checks_total  = 0;
    int checks_passed = 0;
    int pulse_cnt     = 0;

    game_flow_ctrl #(
        .NUM_BRICKS     (NB),
        .INIT_LIVES     (3),
        .DEBOUNCE_CYC   (DEB),
        .RESET_CYC      (RC),
        .SCORE_PER_BRICK(10)
    ) dut (
        .vga_clk        (vga_clk),
        .sys_rst_n      (sys_rst_n),
        .start          (start),
        .lose_sig       (lose_sig),
        .brick_collision(brick_collision),
        .game_state     (game_state),
        .game_reset     (game_reset),
        .lives          (lives),
        .score          (score),
        .bricks_left    (bricks_left)
    );

    always #5 vga_clk = ~vga_clk;

    // Count debounced start pulses seen inside the design.
    always @(posedge vga_clk) begin
        if (dut.start_pulse) pulse_cnt <= pulse_cnt + 1;
    end

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks_total++;
        if (act === exp) checks_passed++;
        else $display("FAIL %s: got %0d, expected %0d", tag, act, exp);
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge vga_clk);
            #1;
        end
    endtask

    task automatic check_all(input string tag, input logic [1:0] gs, input logic gr,
                             input logic [1:0] lv, input logic [15:0] sc, input logic [5:0] bl);
        check({tag, "_state"},  32'(game_state),  32'(gs));
        check({tag, "_reset"},  32'(game_reset),  32'(gr));
        check({tag, "_lives"},  32'(lives),       32'(lv));
        check({tag, "_score"},  32'(score),       32'(sc));
        check({tag, "_bricks"}, 32'(bricks_left), 32'(bl));
    endtask

    // Hold the button and wait (bounded) for the first SERVE cycle.
    task automatic press_wait_serve(input string tag);
        start = 1'b0;
        for (int i = 0; i < 3 * DEB && !game_reset; i++) tick(1);
        check({tag, "_serve_seen"}, 32'(game_reset), 32'd1);
    endtask

    task automatic release_start();
        start = 1'b1;
        tick(DEB + 10);
    endtask

    // Count SERVE cycles from the current sample, then expect PLAY.
    task automatic count_serve(input string tag);
        int n = 0;
        while (game_reset && n < 20) begin
            check({tag, "_serve_gs"}, 32'(game_state), 32'd0);
            n++;
            tick(1);
        end
        check({tag, "_serve_len"}, 32'(n), 32'(RC));
        check({tag, "_to_play"}, 32'(game_state), 32'd1);
    endtask

    initial begin
        // Reset values.
        tick(3);
        check_all("reset", 2'b00, 1'b0, 2'd3, 16'd0, 6'd50);
        sys_rst_n = 1'b1;
        tick(2);

        // Bouncing button must not produce a pulse.
        for (int i = 0; i < 100; i++) begin
            start = ((i % 4) < 2) ? 1'b0 : 1'b1;
            tick(1);
        end
        check("bounce_pulses", 32'(pulse_cnt), 32'd0);
        check("bounce_state", 32'(game_state), 32'd0);

        // Stable press: one serve of RC cycles, then PLAY with fresh counters.
        press_wait_serve("start1");
        count_serve("start1");
        check_all("play1", 2'b01, 1'b0, 2'd3, 16'd0, 6'd50);
        release_start();
        check("start1_pulses", 32'(pulse_cnt), 32'd1);

        // Three bricks hit together and held: counted once.
        brick_collision = '0;
        brick_collision[0]  = 1'b1;
        brick_collision[7]  = 1'b1;
        brick_collision[49] = 1'b1;
        tick(1);
        check_all("hit3", 2'b01, 1'b0, 2'd3, 16'd30, 6'd47);
        tick(19);
        check_all("hit3_hold", 2'b01, 1'b0, 2'd3, 16'd30, 6'd47);
        brick_collision = '0;
        tick(3);
        check_all("hit3_release", 2'b01, 1'b0, 2'd3, 16'd30, 6'd47);

        // Lose two lives with a serve each time.
        lose_sig = 1'b1;
        tick(1);
        check_all("lose1", 2'b00, 1'b1, 2'd2, 16'd30, 6'd47);
        lose_sig = 1'b0;
        count_serve("lose1");
        lose_sig = 1'b1;
        tick(1);
        check_all("lose2", 2'b00, 1'b1, 2'd1, 16'd30, 6'd47);
        lose_sig = 1'b0;
        count_serve("lose2");

        // Last life: game over; score and bricks frozen afterwards.
        lose_sig = 1'b1;
        tick(1);
        check_all("over", 2'b10, 1'b0, 2'd0, 16'd30, 6'd47);
        lose_sig = 1'b0;
        brick_collision[3] = 1'b1;
        tick(3);
        check_all("over_frozen", 2'b10, 1'b0, 2'd0, 16'd30, 6'd47);
        brick_collision = '0;
        tick(1);

        // Restart from OVER; brick edge and stale lose_sig during SERVE are ignored.
        press_wait_serve("restart");
        check_all("restart", 2'b00, 1'b1, 2'd3, 16'd0, 6'd50);
        lose_sig = 1'b1;
        brick_collision[5] = 1'b1;
        tick(1);
        check_all("serve_lose1", 2'b00, 1'b1, 2'd3, 16'd0, 6'd50);
        tick(1);
        lose_sig = 1'b0;
        check_all("serve_lose2", 2'b00, 1'b1, 2'd3, 16'd0, 6'd50);
        tick(2);
        check_all("serve_done", 2'b01, 1'b0, 2'd3, 16'd0, 6'd50);
        release_start();
        check("restart_pulses", 32'(pulse_cnt), 32'd2);
        brick_collision = '0;
        tick(1);
        check_all("play2", 2'b01, 1'b0, 2'd3, 16'd0, 6'd50);

        // 49 bricks, then last brick together with lose_sig: WIN, lives kept.
        brick_collision = {1'b0, {(NB - 1){1'b1}}};
        tick(1);
        check_all("hit49", 2'b01, 1'b0, 2'd3, 16'd490, 6'd1);
        brick_collision = '0;
        tick(1);
        brick_collision[49] = 1'b1;
        lose_sig = 1'b1;
        tick(1);
        check_all("win", 2'b11, 1'b0, 2'd3, 16'd500, 6'd0);
        lose_sig = 1'b0;
        brick_collision = '0;
        brick_collision[2] = 1'b1;
        tick(3);
        check_all("win_frozen", 2'b11, 1'b0, 2'd3, 16'd500, 6'd0);
        brick_collision = '0;
        tick(1);

        // New game from WIN, score 120, then a one-cycle reset mid-play.
        press_wait_serve("game3");
        release_start();
        check("game3_pulses", 32'(pulse_cnt), 32'd3);
        brick_collision = NB'(12'hFFF);
        tick(1);
        check_all("hit12", 2'b01, 1'b0, 2'd3, 16'd120, 6'd38);
        sys_rst_n = 1'b0;
        tick(1);
        check_all("mid_reset", 2'b00, 1'b0, 2'd3, 16'd0, 6'd50);
        sys_rst_n = 1'b1;
        brick_collision = '0;
        tick(3);
        check_all("post_reset", 2'b00, 1'b0, 2'd3, 16'd0, 6'd50);

        $display("%0d/%0d checks passed", checks_passed, checks_total);
        $finish;
    end

endmodule
